// File: rtl/instr_decode_queue.sv
// -----------------------------------------------------------------------------
// instr_decode_queue
//
// Instruction decode stage between fetch and execute. A DEPTH-word circular
// prefetch queue lets fetch run ahead of execution. Each instruction word
// is split into an opcode (MSBs) and two operand fields. Opcodes whose bit
// is set in LONG_MASK take the following word as an immediate.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high; takes priority over flush
//   flush      synchronous clear of queue, staging and out_valid (branch taken)
//   bus_in     instruction word from program memory
//   in_valid   bus_in valid
//   in_ready   queue can accept a word this cycle
//   out_valid  decoded instruction valid
//   out_ready  consumer accepts the decoded instruction
//   opcode     word[WORD_W-1 -: OPC_W]
//   param1     word[2*PARAM_W-1 -: PARAM_W]
//   param2     word[PARAM_W-1:0]
//   imm        immediate word (0 for short instructions)
//   has_imm    current instruction carries an immediate
// -----------------------------------------------------------------------------
module instr_decode_queue #(
  parameter int                  WORD_W    = 16,
  parameter int                  OPC_W     = 4,
  parameter int                  PARAM_W   = (WORD_W - OPC_W) / 2,
  parameter int                  DEPTH     = 4,
  parameter logic [2**OPC_W-1:0] LONG_MASK = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic [WORD_W-1:0]  bus_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic [PARAM_W-1:0] param1,
  output logic [PARAM_W-1:0] param2,
  output logic [WORD_W-1:0]  imm,
  output logic               has_imm
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [0:0] S_OP  = 1'b0;
  localparam logic [0:0] S_IMM = 1'b1;

  logic [WORD_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [0:0]         state_q, state_d;
  logic [WORD_W-1:0]  staging_q, staging_d;
  logic               out_valid_q, out_valid_d;
  logic [OPC_W-1:0]   opcode_q, opcode_d;
  logic [PARAM_W-1:0] param1_q, param1_d;
  logic [PARAM_W-1:0] param2_q, param2_d;
  logic [WORD_W-1:0]  imm_q, imm_d;
  logic               has_imm_q, has_imm_d;

  logic              push, pop, load, not_empty, slot_free, head_long;
  logic [WORD_W-1:0] head, load_word, load_imm;
  logic              load_has;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // in_ready depends only on registered count plus reset/flush, never on
  // in_valid or out_ready.
  assign in_ready  = (count_q < FULL_CNT) && !reset && !flush;
  assign push      = in_valid && in_ready;
  assign not_empty = (count_q != '0);
  assign slot_free = !out_valid_q || out_ready;
  assign head      = mem_q[rd_ptr_q];
  assign head_long = LONG_MASK[head[WORD_W-1 -: OPC_W]];

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    pop       = 1'b0;
    load      = 1'b0;
    load_word = head;
    load_imm  = '0;
    load_has  = 1'b0;
    state_d   = state_q;
    staging_d = staging_q;

    case (state_q)
      S_OP: begin
        if (not_empty) begin
          if (head_long) begin
            // Staging is always empty in S_OP, so the opcode word can be
            // taken even while the output slot is stalled.
            pop       = 1'b1;
            staging_d = head;
            state_d   = S_IMM;
          end else if (slot_free) begin
            pop  = 1'b1;
            load = 1'b1;
          end
        end
      end
      default: begin
        if (not_empty && slot_free) begin
          pop       = 1'b1;
          load      = 1'b1;
          load_word = staging_q;
          load_imm  = head;
          load_has  = 1'b1;
          staging_d = '0;
          state_d   = S_OP;
        end
      end
    endcase

    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Fields hold unless a new instruction loads; out_valid drops only once
    // the current instruction has been taken.
    opcode_d    = load ? load_word[WORD_W-1 -: OPC_W]      : opcode_q;
    param1_d    = load ? load_word[2*PARAM_W-1 -: PARAM_W] : param1_q;
    param2_d    = load ? load_word[PARAM_W-1:0]            : param2_q;
    imm_d       = load ? load_imm                          : imm_q;
    has_imm_d   = load ? load_has                          : has_imm_q;
    out_valid_d = load || (out_valid_q && !out_ready);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_OP;
      staging_q   <= '0;
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      param1_q    <= '0;
      param2_q    <= '0;
      imm_q       <= '0;
      has_imm_q   <= 1'b0;
    end else if (flush) begin
      // Decoded fields deliberately keep their last values.
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_OP;
      staging_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      staging_q   <= staging_d;
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      param1_q    <= param1_d;
      param2_q    <= param2_d;
      imm_q       <= imm_d;
      has_imm_q   <= has_imm_d;
    end
  end

  // NOTE: queue storage has no reset; count gates every read, so stale
  // contents are never observed.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= bus_in;
  end

  assign out_valid = out_valid_q;
  assign opcode    = opcode_q;
  assign param1    = param1_q;
  assign param2    = param2_q;
  assign imm       = imm_q;
  assign has_imm   = has_imm_q;

endmodule

// File: doc/instr_decode_queue.md
# instr_decode_queue

Parametrised instruction decode stage with a DEPTH-word prefetch queue and valid/ready handshakes on both sides. Words arrive from the program-memory bus and are split into opcode and two operand fields. Opcodes flagged in LONG_MASK consume the following word as an immediate. The block sits between instruction fetch and the execute/control unit and lets fetch run ahead of execution by up to DEPTH words.

## Interface
- WORD_W, 16: instruction word width.
- OPC_W, 4: opcode width, taken from the MSBs of the word.
- PARAM_W, (WORD_W-OPC_W)/2: width of each operand field. WORD_W-OPC_W must be even.
- DEPTH, 4: prefetch queue depth in words; must be at least 2.
- LONG_MASK, 16'h0000: 2**OPC_W bits. Bit k set means opcode k carries one immediate word.

Ports (reset reset, synchronous, active-high; clock clock):
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high.
- flush, input, 1: synchronous queue/decoder clear (branch taken).
- bus_in, input, WORD_W: incoming instruction word.
- in_valid, input, 1: bus_in valid.
- in_ready, output, 1: queue can accept a word.
- out_valid, output, 1: decoded instruction valid.
- out_ready, input, 1: consumer accepts the decoded instruction.
- opcode, output, OPC_W: word[WORD_W-1 -: OPC_W].
- param1, output, PARAM_W: word[2*PARAM_W-1 -: PARAM_W].
- param2, output, PARAM_W: word[PARAM_W-1:0].
- imm, output, WORD_W: immediate word; 0 for short instructions.
- has_imm, output, 1: current instruction is long.

## Operation
- **Queue:** circular buffer of DEPTH words with read/write pointers that wrap DEPTH-1→0 and a count of width $clog2(DEPTH+1).
  - Push when in_valid && in_ready.
  - in_ready = (count < DEPTH) && !reset && !flush.
  - No bypass: a push into a full queue is refused even if a pop occurs in the same cycle.
- **Output slot:** one register set (opcode, param1, param2, imm, has_imm, out_valid). The slot is "free" when out_valid==0 or out_ready==1.
- **FSM states:**
  - S_OP: if queue not empty and slot free, pop the head word.
    - Opcode not in LONG_MASK: load the slot with imm=0, has_imm=0, out_valid=1.
    - Opcode in LONG_MASK: latch the word into a staging register and go to S_IMM. This pop does not require a free slot, only that staging is empty, which is always true in S_OP.
  - S_IMM: if queue not empty and slot free, pop the word into imm and load the slot from staging with has_imm=1, out_valid=1. Return to S_OP.
- If the slot is not refilled in a cycle where out_ready && out_valid, out_valid clears.
- Outputs hold stable while out_valid && !out_ready.
- **Flush:** count, pointers and staging clear; state returns to S_OP; out_valid=0; field outputs are unchanged. A push in the flush cycle is dropped. A flush coinciding with out_ready has no effect beyond the clear.
- **Reset:** count=0, pointers=0, state=S_OP, out_valid=0, opcode/param1/param2/imm=0, has_imm=0, staging=0.
  - Reset asserted mid-instruction (in S_IMM) discards the pending opcode.
  - Reset takes priority over flush.

## Timing
- Push at edge N. If the queue was empty and the slot free, a short instruction is out_valid after edge N+1, giving 1 cycle of queue-to-output latency.
- A long instruction whose two words are pushed at edges N and N+1 is out_valid after edge N+2.
- **Throughput:** one short instruction per cycle while out_ready=1. A long instruction takes 2 pops, so at most one per 2 cycles.
- Simultaneous push and pop at count==DEPTH-1 or below: count is unchanged.
- Simultaneous push and pop on an empty queue: the word is not popped that cycle.
- in_ready and out_valid have no combinational path from in_valid or out_ready.

## Test plan
- **Reset:** hold reset 2 cycles with in_valid=1 → in_ready=0, out_valid=0, all fields 0. After release, in_ready=1 next cycle.
- **Short stream:** defaults, LONG_MASK=0, push 16'h1234, 16'hA5C3, 16'hFFFF with out_ready=1.
  - Outputs (opcode, param1, param2) = (1,8,34), (A,17,03), (F,3F,3F) on consecutive cycles, first appearing one cycle after the push.
  - imm=0 throughout.
- **Long instruction:** LONG_MASK=16'h0080, push 16'h7041 then 16'hBEEF → one output with opcode=7, param1=01, param2=01, has_imm=1, imm=16'hBEEF. The next word decodes as short.
- **Backpressure/full:** out_ready=0, push 6 words at DEPTH=4.
  - 1 word goes to the slot and 4 to the queue; in_ready=0 after the 5th.
  - Raise out_ready → all 5 emerge in order with no loss or duplication. Outputs stay stable while stalled.
- **Flush:** flush while in S_IMM with 2 words queued and out_valid=1 → next cycle out_valid=0, count=0. A subsequent short word decodes normally, not as an immediate.
- **Wrap-around:** DEPTH=3, stream 20 random words with random out_ready/in_valid → decoded sequence matches the reference model, pointers wrap correctly, never over/underflow.
